// File: rtl/arbiter8_rr_pkg.sv
// Shared constants for the 8-way round-robin arbiter and its bench.
package arbiter8_rr_pkg;

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;
  localparam int unsigned HoldW  = 8;

  // Search after reset starts at index 0.
  localparam logic [IdxW-1:0] LastIdRst = 3'd7;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/onehot8_to_bin3.sv
// Combinational one-hot to binary encoder; all-zero input encodes to 0.
module onehot8_to_bin3 (
  input  logic [7:0] oh_i,
  output logic [2:0] bin_o
);

  // OR together the indices of set bits; exact for one-hot or zero input.
  always_comb begin
    bin_o = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (oh_i[i]) begin
        bin_o = bin_o | 3'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter8_rr.sv
// 8-requester round-robin arbiter with done/req-drop release and a hold limit.
module arbiter8_rr
  import arbiter8_rr_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NumReq-1:0]   req,
  input  logic                done,
  output logic [NumReq-1:0]   gnt,
  output logic [IdxW-1:0]     gnt_id,
  output logic                gnt_valid,
  output logic                timeout
);

  state_e              state_q, state_d;
  logic [NumReq-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]     gnt_id_q, gnt_id_d;
  logic                valid_q;
  logic                timeout_q, timeout_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [IdxW-1:0]     last_id_q, last_id_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_id;
  logic                own_req;
  logic                expire;
  logic                release_now;
  logic                new_grant;

  // Round-robin search starting just after the last winner.
  always_comb begin : rr_search
    logic [IdxW-1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = IdxW'(32'(last_id_q) + k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Release terms for the current owner; the owner's own request only survives
  // into the search on done/expiry, which gives the same-owner wrap re-grant.
  always_comb begin
    own_req     = req[gnt_id_q];
    expire      = (hold_q == HoldW'(MAX_HOLD - 1));
    release_now = done | ~own_req | expire;
    new_grant   = pick_found & ((state_q == StIdle) | release_now);
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      last_id_q <= LastIdRst;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= |gnt_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      last_id_q <= last_id_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pick_found) state_d = StBusy;
      StBusy: if (release_now && !pick_found) state_d = StIdle;
    endcase
  end

  // Next grant, hold count, last winner and timeout pulse.
  always_comb begin
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    last_id_d = last_id_q;
    timeout_d = 1'b0;
    if (new_grant) begin
      gnt_d     = NumReq'(1) << pick_id;
      last_id_d = pick_id;
      hold_d    = '0;
    end else if (state_q == StBusy) begin
      if (release_now) begin
        gnt_d  = '0;
        hold_d = '0;
      end else if (hold_q != {HoldW{1'b1}}) begin
        hold_d = hold_q + HoldW'(1);
      end
    end
    // Done or req-drop coinciding with expiry is a normal release.
    if ((state_q == StBusy) && expire && !done && own_req) begin
      timeout_d = 1'b1;
    end
  end

  onehot8_to_bin3 u_enc (
    .oh_i  (gnt_d),
    .bin_o (gnt_id_d)
  );

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Bench for arbiter8_rr: directed vector table, a hold-limit sequence and
// randomized traffic against a behavioural model.
module tb_arbiter8_rr;
  import arbiter8_rr_pkg::*;

  localparam int MaxHold = 4;

  logic              clk;
  logic              rst_n;
  logic [NumReq-1:0] req;
  logic              done;
  logic [NumReq-1:0] gnt;
  logic [IdxW-1:0]   gnt_id;
  logic              gnt_valid;
  logic              timeout;

  int n_cmp = 0;
  int n_bad = 0;

  arbiter8_rr #(.MAX_HOLD(MaxHold)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic r, logic [7:0] rq, logic d, logic [7:0] g, logic [2:0] i,
                              logic v, logic t);
    vec_t x;
    x.rst_n = r; x.req = rq; x.done = d; x.gnt = g; x.id = i; x.valid = v; x.to = t;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the edge, then settle just after the rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic d);
    @(negedge clk);
    rst_n = r; req = rq; done = d;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: owner index (-1 = none), cycles held, last winner.
  int m_owner, m_last, m_held;
  bit m_to;

  function automatic int rr_pick(logic [7:0] r, int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [7:0] rq, input logic d);
    bit own, lim;
    if (!r) begin
      m_owner = -1; m_last = 7; m_held = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      if (rq != 0) begin
        m_owner = rr_pick(rq, m_last); m_last = m_owner; m_held = 1;
      end
    end else begin
      own  = rq[m_owner];
      lim  = (m_held == MaxHold);
      m_to = lim && !d && own;
      if (d || !own || lim) begin
        if (rq != 0) begin
          m_owner = rr_pick(rq, m_last); m_last = m_owner; m_held = 1;
        end else begin
          m_owner = -1; m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  initial begin
    int cnt, drops;
    logic [7:0] rq;
    logic r, d;
    rst_n = 1'b0; req = '0; done = 1'b0;

    // Directed table, MAX_HOLD = 4.
    vecs[0]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 0);  // reset state
    vecs[1]  = mk(1, 8'h01, 0, 8'h01, 0, 1, 0);  // first grant, 1-cycle latency
    vecs[2]  = mk(1, 8'hFF, 1, 8'h02, 1, 1, 0);  // back-to-back rotation
    vecs[3]  = mk(1, 8'hFF, 1, 8'h04, 2, 1, 0);
    vecs[4]  = mk(1, 8'hFF, 1, 8'h08, 3, 1, 0);
    vecs[5]  = mk(1, 8'hFF, 1, 8'h10, 4, 1, 0);
    vecs[6]  = mk(1, 8'hFF, 1, 8'h20, 5, 1, 0);
    vecs[7]  = mk(1, 8'hFF, 1, 8'h40, 6, 1, 0);
    vecs[8]  = mk(1, 8'hFF, 1, 8'h80, 7, 1, 0);
    vecs[9]  = mk(1, 8'hFF, 1, 8'h01, 0, 1, 0);  // wrap to 0
    vecs[10] = mk(1, 8'h04, 1, 8'h04, 2, 1, 0);  // last_id becomes 2
    vecs[11] = mk(1, 8'h82, 1, 8'h80, 7, 1, 0);  // search from 3 finds 7
    vecs[12] = mk(1, 8'h82, 1, 8'h02, 1, 1, 0);  // then 1 after done
    vecs[13] = mk(1, 8'h20, 1, 8'h20, 5, 1, 0);
    vecs[14] = mk(1, 8'h40, 0, 8'h40, 6, 1, 0);  // owner 5 drops, 6 granted
    vecs[15] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);  // hold cycle 1
    vecs[16] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);
    vecs[17] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);
    vecs[18] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);  // hold cycle 4
    vecs[19] = mk(1, 8'h08, 0, 8'h08, 3, 1, 1);  // revoked, same owner re-granted
    vecs[20] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);
    vecs[21] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);
    vecs[22] = mk(1, 8'h08, 0, 8'h08, 3, 1, 0);
    vecs[23] = mk(1, 8'h08, 1, 8'h08, 3, 1, 0);  // done at expiry: no timeout
    vecs[24] = mk(1, 8'h00, 0, 8'h00, 0, 0, 0);  // drop, nobody else: idle
    vecs[25] = mk(1, 8'h00, 1, 8'h00, 0, 0, 0);  // done in idle ignored
    vecs[26] = mk(1, 8'h10, 1, 8'h10, 4, 1, 0);
    vecs[27] = mk(0, 8'h10, 0, 8'h00, 0, 0, 0);  // reset mid-grant
    vecs[28] = mk(1, 8'h80, 0, 8'h80, 7, 1, 0);  // first search after reset

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d.gnt", i),       gnt,       vecs[i].gnt);
      chk($sformatf("vec%0d.gnt_id", i),    gnt_id,    vecs[i].id);
      chk($sformatf("vec%0d.gnt_valid", i), gnt_valid, vecs[i].valid);
      chk($sformatf("vec%0d.timeout", i),   timeout,   vecs[i].to);
    end

    // Hold-limit sequence: count edges until timeout, grant never gaps.
    step(0, 8'h00, 0);
    cnt = 0; drops = 0;
    do begin
      step(1, 8'h08, 0);
      cnt++;
      if (!gnt_valid || gnt != 8'h08) drops++;
    end while (!timeout && cnt < 20);
    chk("hold_timeout_edges", cnt, MaxHold + 1);
    chk("hold_grant_gaps", drops, 0);
    step(1, 8'h08, 0);
    chk("hold_timeout_one_cycle", timeout, 0);

    // Randomized traffic against the model.
    step(0, 8'h00, 0);
    model_step(0, 8'h00, 0);
    rq = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        rq = 8'($urandom);
        if ($urandom_range(0, 1) == 1) rq = rq & 8'($urandom) & 8'($urandom);
      end
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) != 0);
      step(r, rq, d);
      model_step(r, rq, d);
      chk("rand.gnt", gnt, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("rand.gnt_id", gnt_id, (m_owner < 0) ? 0 : m_owner);
      chk("rand.gnt_valid", gnt_valid, (m_owner >= 0) ? 1 : 0);
      chk("rand.timeout", timeout, m_to ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
